pipe_perf_monitor: RTL

//   Cycle-accurate performance/termination monitor for the 5-stage pipelined CPU.

---
 rtl/pipe_perf_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_perf_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_perf_monitor : cycle/stall/flush/retire counters with snapshot and done
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int IDLE_LIMIT = 8,
  parameter int PC_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic             snap_valid_o,
  output logic [1:0]       state_o,
  output logic             done_o
);

  localparam int C_IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam logic [C_IDLE_W-1:0] C_IDLE_LIMIT = C_IDLE_W'(IDLE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cycle, r_stall, r_flush, r_retire;
  logic [CNT_W-1:0]    w_cycle_nxt, w_stall_nxt, w_flush_nxt, w_retire_nxt;
  logic [CNT_W-1:0]    r_snap_cycle, r_snap_retire;
  logic                r_snap_valid;
  logic [C_IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [PC_W-1:0]     r_prev_pc;
  logic                r_pc_vld;
  logic                w_run, w_pc_same;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_run = (r_state == S_RUN);
  // r_pc_vld is low on the first RUN edge, so that edge always counts as a PC change
  assign w_pc_same = r_pc_vld && !retire_i && (pc_i == r_prev_pc);

  always_comb begin
    w_idle_nxt   = '0;
    w_cycle_nxt  = r_cycle;
    w_stall_nxt  = r_stall;
    w_flush_nxt  = r_flush;
    w_retire_nxt = r_retire;
    if (w_pc_same)
      w_idle_nxt = (r_idle_cnt == C_IDLE_LIMIT) ? r_idle_cnt : r_idle_cnt + 1'b1;
    if (w_run) begin
      w_cycle_nxt = sat_inc(r_cycle);
      if (flush_i)
        w_flush_nxt = sat_inc(r_flush);
      else if (stall_i)
        w_stall_nxt = sat_inc(r_stall);
      if (retire_i)
        w_retire_nxt = sat_inc(r_retire);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!start_i)
          w_state_nxt = S_IDLE;
        else if (w_idle_nxt == C_IDLE_LIMIT)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear_i)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycle       <= '0;
      r_stall       <= '0;
      r_flush       <= '0;
      r_retire      <= '0;
      r_snap_cycle  <= '0;
      r_snap_retire <= '0;
      r_snap_valid  <= 1'b0;
      r_idle_cnt    <= '0;
      r_prev_pc     <= '0;
      r_pc_vld      <= 1'b0;
    end else if (clear_i) begin
      r_cycle       <= '0;
      r_stall       <= '0;
      r_flush       <= '0;
      r_retire      <= '0;
      r_snap_cycle  <= '0;
      r_snap_retire <= '0;
      r_snap_valid  <= 1'b0;
      r_idle_cnt    <= '0;
      r_prev_pc     <= '0;
      r_pc_vld      <= 1'b0;
    end else begin
      r_cycle      <= w_cycle_nxt;
      r_stall      <= w_stall_nxt;
      r_flush      <= w_flush_nxt;
      r_retire     <= w_retire_nxt;
      r_snap_valid <= snap_i;
      r_prev_pc    <= pc_i;
      r_pc_vld     <= w_run;
      if (w_run)
        r_idle_cnt <= w_idle_nxt;
      // snapshot takes this edge's post-update values so all fields are coherent
      if (snap_i) begin
        r_snap_cycle  <= w_cycle_nxt;
        r_snap_retire <= w_retire_nxt;
      end
    end
  end

  assign cycle_o       = r_cycle;
  assign stall_cnt_o   = r_stall;
  assign flush_cnt_o   = r_flush;
  assign retire_cnt_o  = r_retire;
  assign snap_cycle_o  = r_snap_cycle;
  assign snap_retire_o = r_snap_retire;
  assign snap_valid_o  = r_snap_valid;
  assign state_o       = r_state;
  assign done_o        = (r_state == S_DONE);

endmodule
`default_nettype wire
